multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle RV32 datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable, and it produces the `alu_op`/`funct` pair consumed by the ALU control decoder. It sits between the instruction register and the datapath muxes, and handles memory wait states through a `mem_ready` handshake.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `instr`, input, 32: instruction register contents; valid from DECODE onward.
- `zero`, input, 1: ALU zero flag.
- `mem_ready`, input, 1: memory completes the current access this cycle.
- `pc_en`, output, 1: PC register write enable.
- `pc_src`, output, 1: 0 = ALU result, 1 = ALUOut (branch target).
- `ir_write`, output, 1: instruction register load.
- `i_or_d`, output, 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read`, output, 1: memory read strobe.
- `mem_write`, output, 1: memory write strobe.
- `reg_write`, output, 1: register file write.
- `mem_to_reg`, output, 1: writeback select; 1 = MDR.
- `alu_src_a`, output, 1: 0 = PC, 1 = register A.
- `alu_src_b`, output, 2: 00 = register B, 01 = constant 4, 10 = immediate.
- `alu_op`, output, 2: 00 = add, 01 = subtract, 10 = use funct.
- `funct`, output, 4: `{instr[30], instr[14:12]}`, registered in DECODE.
- `illegal`, output, 1: one-cycle pulse on an unsupported opcode.
- `retire_cnt`, output, CNT_W: count of completed instructions.
- `state`, output, 4: current state encoding, for debug.

## Operation
State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8. Unused encodings go to FETCH.

- **FETCH**
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - ir_write and pc_en follow `mem_ready`.
  - Holds in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.
- **DECODE**
  - Drives alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut).
  - Latches `funct`.
  - Next state from `instr[6:0]`: 0000011 or 0100011 → MEM_ADDR; 0110011 → EXECUTE; 1100011 → BRANCH.
  - Any other opcode → FETCH with illegal=1.
- **MEM_ADDR**
  - Drives alu_src_a=1, alu_src_b=10, alu_op=00.
  - Goes to MEM_READ for a load, MEM_WRITE for a store.
- **MEM_READ**
  - Drives mem_read=1, i_or_d=1.
  - Holds until mem_ready=1, then goes to MEM_WB.
- **MEM_WB**
  - Drives reg_write=1, mem_to_reg=1; then FETCH (retire).
- **MEM_WRITE**
  - Drives mem_write=1, i_or_d=1.
  - Holds until mem_ready=1, then goes to FETCH (retire).
- **EXECUTE**
  - Drives alu_src_a=1, alu_src_b=00, alu_op=10; then ALU_WB.
- **ALU_WB**
  - Drives reg_write=1, mem_to_reg=0; then FETCH (retire).
- **BRANCH**
  - Drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_en=zero; then FETCH (retire).

Output and counter rules:
- Outputs not listed for a state are 0.
- Outputs are decoded from state; the mem_ready and zero terms are combinational gating.
- `retire_cnt` increments by 1 on each retiring transition and wraps modulo 2^CNT_W.
- An illegal opcode does not retire.

## Timing
- Reset: while rst_n=0, all strobes (pc_en, ir_write, mem_read, mem_write, reg_write) are forced to 0 combinationally.
- After the reset edge: state=FETCH, funct=0, retire_cnt=0, illegal=0.
- Reset mid-instruction abandons the instruction; it does not retire and produces no write strobe after the edge.
- Latency with mem_ready always high:
  - R-type: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Beq: 3 cycles.
  - Illegal: 2 cycles.
- Each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- While waiting, the strobe and i_or_d stay stable.
- `funct` is stable from the cycle after DECODE until the next DECODE.
- `alu_op` is valid in the same cycle as the state it belongs to.

## Structure
- Shared package `ctrl_pkg`:
  - state encodings;
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH);
  - ALUOp constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - alu_src_b select constants.
- Sub-module `control_out_decode`: purely combinational map from state, mem_ready and zero to the strobe and select outputs.
- The top level holds the state register, the funct latch and the retire counter.

## Test plan
- **Reset and R-type:** reset, then `instr=0x40B50533` (sub) with mem_ready=1.
  - States 0→1→6→7→0.
  - funct=1000 and alu_op=10 in EXECUTE.
  - reg_write=1 only in ALU_WB.
  - retire_cnt=1.
- **Load with waits:** `instr=0x0002A303` (lw), mem_ready low for 2 cycles in MEM_READ.
  - MEM_READ lasts 3 cycles with mem_read=1 and i_or_d=1 throughout.
  - mem_to_reg=1 in MEM_WB.
  - Total 7 cycles.
- **Beq:** `instr=0x00628463`, once with zero=1 and once with zero=0.
  - pc_en=1 with pc_src=1 in BRANCH when zero=1.
  - pc_en=0 in BRANCH when zero=0.
  - alu_op=01 in both cases.
- **Illegal opcode:** `instr=0x0000007F`.
  - illegal=1 for exactly the DECODE cycle, then FETCH.
  - retire_cnt unchanged.
- **Reset mid-operation:** rst_n=0 during MEM_WRITE with mem_ready=0.
  - mem_write drops immediately.
  - state=0 and retire_cnt=0 after the edge.
- **Counter wrap:** CNT_W=4, run 17 R-types.
  - retire_cnt=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control FSM: states, opcodes,
// ALUOp codes and ALU B-operand selects.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/control_out_decode.sv
// Combinational map from control state (plus mem_ready / zero gating) to
// every datapath strobe and mux select.
module control_out_decode
   import ctrl_pkg::*;
(
   input  state_t     state_i,
   input  logic       mem_ready_i,
   input  logic       zero_i,
   output logic       pc_en_o,
   output logic       pc_src_o,
   output logic       ir_write_o,
   output logic       i_or_d_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       reg_write_o,
   output logic       mem_to_reg_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [1:0] alu_op_o
);

   always_comb begin
      pc_en_o      = 1'b0;
      pc_src_o     = 1'b0;
      ir_write_o   = 1'b0;
      i_or_d_o     = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      reg_write_o  = 1'b0;
      mem_to_reg_o = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = SRCB_REG;
      alu_op_o     = ALUOP_ADD;
      case (state_i)
         S_FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = SRCB_FOUR;
            ir_write_o  = mem_ready_i;
            pc_en_o     = mem_ready_i;
         end
         S_DECODE:    alu_src_b_o = SRCB_IMM;
         S_MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_IMM;
         end
         S_MEM_READ: begin
            mem_read_o = 1'b1;
            i_or_d_o   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_write_o = 1'b1;
            i_or_d_o    = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALUOP_FUNCT;
         end
         S_ALU_WB:    reg_write_o = 1'b1;
         S_BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALUOP_SUB;
            pc_src_o    = 1'b1;
            pc_en_o     = zero_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main multicycle RV32 control FSM: state register, funct latch and
// retired-instruction counter; strobes come from control_out_decode.
//
// state     | meaning
// ----------+-------------------------------------------------
// FETCH     | read instruction at PC, PC+4, wait on mem_ready
// DECODE    | branch target into ALUOut, latch funct, dispatch
// MEM_ADDR  | rs1 + imm address calculation for load/store
// MEM_READ  | load data read, wait on mem_ready
// MEM_WB    | MDR into register file (retire)
// MEM_WRITE | store data write, wait on mem_ready (retire)
// EXECUTE   | R-type ALU operation
// ALU_WB    | ALUOut into register file (retire)
// BRANCH    | beq compare, PC <- ALUOut when zero (retire)
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instr,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             pc_src,
   output logic             ir_write,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [3:0]       funct,
   output logic             illegal,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [3:0]       state
);

   state_t           state_q, state_d;
   logic [3:0]       funct_q;
   logic [CNT_W-1:0] retire_q;
   logic             retire;
   logic             op_legal;
   logic [6:0]       opcode;
   logic             pc_en_raw, ir_write_raw, mem_read_raw, mem_write_raw, reg_write_raw;
   logic             unused_instr;

   assign opcode       = instr[6:0];
   assign unused_instr = &{1'b0, instr[31], instr[29:15], instr[11:7]};

   always_comb begin
      state_d  = S_FETCH;
      retire   = 1'b0;
      op_legal = (opcode == OP_LOAD) || (opcode == OP_STORE) ||
                 (opcode == OP_RTYPE) || (opcode == OP_BRANCH);
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if ((opcode == OP_LOAD) || (opcode == OP_STORE)) state_d = S_MEM_ADDR;
            else if (opcode == OP_RTYPE)                     state_d = S_EXECUTE;
            else if (opcode == OP_BRANCH)                    state_d = S_BRANCH;
            else                                             state_d = S_FETCH;
         end
         S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ: state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WB:   retire  = 1'b1;
         S_MEM_WRITE: begin
            state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            retire  = mem_ready;
         end
         S_EXECUTE:  state_d = S_ALU_WB;
         S_ALU_WB:   retire  = 1'b1;
         S_BRANCH:   retire  = 1'b1;
         default:    state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         funct_q  <= 4'd0;
         retire_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) funct_q <= {instr[30], instr[14:12]};
         if (retire) retire_q <= retire_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   control_out_decode u_dec (
      .state_i      (state_q),
      .mem_ready_i  (mem_ready),
      .zero_i       (zero),
      .pc_en_o      (pc_en_raw),
      .pc_src_o     (pc_src),
      .ir_write_o   (ir_write_raw),
      .i_or_d_o     (i_or_d),
      .mem_read_o   (mem_read_raw),
      .mem_write_o  (mem_write_raw),
      .reg_write_o  (reg_write_raw),
      .mem_to_reg_o (mem_to_reg),
      .alu_src_a_o  (alu_src_a),
      .alu_src_b_o  (alu_src_b),
      .alu_op_o     (alu_op)
   );

   // strobes are killed the moment reset asserts, without waiting for the edge
   assign pc_en      = pc_en_raw     & rst_n;
   assign ir_write   = ir_write_raw  & rst_n;
   assign mem_read   = mem_read_raw  & rst_n;
   assign mem_write  = mem_write_raw & rst_n;
   assign reg_write  = reg_write_raw & rst_n;

   assign illegal    = (state_q == S_DECODE) && !op_legal;
   assign funct      = funct_q;
   assign retire_cnt = retire_q;
   assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed cycle-by-cycle vector bench for multicycle_control; a second
// instance with a 4-bit counter shares the stimulus to exercise wrap.
module tb_multicycle_control;

   typedef struct {
      logic        rst_n;
      logic [31:0] instr;
      logic        zero;
      logic        mr;
      logic [3:0]  st;
      logic [10:0] ctl;
      logic [1:0]  aop;
      logic        ill;
      logic [3:0]  fn;
      logic [31:0] rc;
   } vec_t;

   // ctl = {pc_en,pc_src,ir_write,i_or_d,mem_read,mem_write,reg_write,mem_to_reg,alu_src_a,alu_src_b[1:0]}
   localparam logic [10:0] C_RST = 11'b0_0_0_0_0_0_0_0_0_01;
   localparam logic [10:0] C_F1  = 11'b1_0_1_0_1_0_0_0_0_01;
   localparam logic [10:0] C_F0  = 11'b0_0_0_0_1_0_0_0_0_01;
   localparam logic [10:0] C_DEC = 11'b0_0_0_0_0_0_0_0_0_10;
   localparam logic [10:0] C_MA  = 11'b0_0_0_0_0_0_0_0_1_10;
   localparam logic [10:0] C_MR  = 11'b0_0_0_1_1_0_0_0_0_00;
   localparam logic [10:0] C_MWB = 11'b0_0_0_0_0_0_1_1_0_00;
   localparam logic [10:0] C_MW  = 11'b0_0_0_1_0_1_0_0_0_00;
   localparam logic [10:0] C_MWR = 11'b0_0_0_1_0_0_0_0_0_00;
   localparam logic [10:0] C_EXE = 11'b0_0_0_0_0_0_0_0_1_00;
   localparam logic [10:0] C_AWB = 11'b0_0_0_0_0_0_1_0_0_00;
   localparam logic [10:0] C_BR1 = 11'b1_1_0_0_0_0_0_0_1_00;
   localparam logic [10:0] C_BR0 = 11'b0_1_0_0_0_0_0_0_1_00;

   localparam logic [31:0] I_SUB = 32'h40B50533;
   localparam logic [31:0] I_LW  = 32'h0002A303;
   localparam logic [31:0] I_SW  = 32'h0062A023;
   localparam logic [31:0] I_BEQ = 32'h00628463;
   localparam logic [31:0] I_ILL = 32'h0000007F;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        zero, mem_ready;

   logic        pc_en, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg, alu_src_a;
   logic [1:0]  alu_src_b, alu_op;
   logic [3:0]  funct, state;
   logic        illegal;
   logic [31:0] retire_cnt;

   logic        n_pc_en, n_pc_src, n_ir_write, n_i_or_d, n_mem_read, n_mem_write, n_reg_write, n_mem_to_reg, n_alu_src_a;
   logic [1:0]  n_alu_src_b, n_alu_op;
   logic [3:0]  n_funct, n_state;
   logic        n_illegal;
   logic [3:0]  n_retire_cnt;

   int total = 0;
   int bad   = 0;
   vec_t vq[$];

   always #5 clk = ~clk;

   multicycle_control u_dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .funct(funct), .illegal(illegal), .retire_cnt(retire_cnt),
      .state(state)
   );

   multicycle_control #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .pc_en(n_pc_en), .pc_src(n_pc_src), .ir_write(n_ir_write), .i_or_d(n_i_or_d),
      .mem_read(n_mem_read), .mem_write(n_mem_write), .reg_write(n_reg_write),
      .mem_to_reg(n_mem_to_reg), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
      .alu_op(n_alu_op), .funct(n_funct), .illegal(n_illegal), .retire_cnt(n_retire_cnt),
      .state(n_state)
   );

   task automatic add(input logic r, input logic [31:0] i, input logic z, input logic m,
                      input logic [3:0] st, input logic [10:0] c, input logic [1:0] a,
                      input logic il, input logic [3:0] fn, input logic [31:0] rc);
      vec_t v;
      v.rst_n = r; v.instr = i; v.zero = z; v.mr = m; v.st = st; v.ctl = c;
      v.aop = a; v.ill = il; v.fn = fn; v.rc = rc;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
      end
   endtask

   initial begin
      logic [31:0] rc_w;
      rst_n = 1'b0; instr = 32'd0; zero = 1'b0; mem_ready = 1'b1;

      // reset
      add(0, 32'd0, 0, 1, 4'd0, C_RST, 2'b00, 0, 4'h0, 0);
      // R-type sub
      add(1, I_SUB, 0, 1, 4'd0, C_F1,  2'b00, 0, 4'h0, 0);
      add(1, I_SUB, 0, 1, 4'd1, C_DEC, 2'b00, 0, 4'h0, 0);
      add(1, I_SUB, 0, 1, 4'd6, C_EXE, 2'b10, 0, 4'h8, 0);
      add(1, I_SUB, 0, 1, 4'd7, C_AWB, 2'b00, 0, 4'h8, 0);
      // load with two wait cycles in MEM_READ
      add(1, I_LW, 0, 1, 4'd0, C_F1,  2'b00, 0, 4'h8, 1);
      add(1, I_LW, 0, 1, 4'd1, C_DEC, 2'b00, 0, 4'h8, 1);
      add(1, I_LW, 0, 1, 4'd2, C_MA,  2'b00, 0, 4'h2, 1);
      add(1, I_LW, 0, 0, 4'd3, C_MR,  2'b00, 0, 4'h2, 1);
      add(1, I_LW, 0, 0, 4'd3, C_MR,  2'b00, 0, 4'h2, 1);
      add(1, I_LW, 0, 1, 4'd3, C_MR,  2'b00, 0, 4'h2, 1);
      add(1, I_LW, 0, 1, 4'd4, C_MWB, 2'b00, 0, 4'h2, 1);
      // beq taken / not taken
      add(1, I_BEQ, 1, 1, 4'd0, C_F1,  2'b00, 0, 4'h2, 2);
      add(1, I_BEQ, 1, 1, 4'd1, C_DEC, 2'b00, 0, 4'h2, 2);
      add(1, I_BEQ, 1, 1, 4'd8, C_BR1, 2'b01, 0, 4'h0, 2);
      add(1, I_BEQ, 0, 1, 4'd0, C_F1,  2'b00, 0, 4'h0, 3);
      add(1, I_BEQ, 0, 1, 4'd1, C_DEC, 2'b00, 0, 4'h0, 3);
      add(1, I_BEQ, 0, 1, 4'd8, C_BR0, 2'b01, 0, 4'h0, 3);
      // illegal opcode: no retire
      add(1, I_ILL, 0, 1, 4'd0, C_F1,  2'b00, 0, 4'h0, 4);
      add(1, I_ILL, 0, 1, 4'd1, C_DEC, 2'b00, 1, 4'h0, 4);
      // store with one fetch wait
      add(1, I_SW, 0, 0, 4'd0, C_F0,  2'b00, 0, 4'h0, 4);
      add(1, I_SW, 0, 1, 4'd0, C_F1,  2'b00, 0, 4'h0, 4);
      add(1, I_SW, 0, 1, 4'd1, C_DEC, 2'b00, 0, 4'h0, 4);
      add(1, I_SW, 0, 1, 4'd2, C_MA,  2'b00, 0, 4'h2, 4);
      add(1, I_SW, 0, 1, 4'd5, C_MW,  2'b00, 0, 4'h2, 4);
      // store abandoned by reset while waiting in MEM_WRITE
      add(1, I_SW, 0, 1, 4'd0, C_F1,  2'b00, 0, 4'h2, 5);
      add(1, I_SW, 0, 1, 4'd1, C_DEC, 2'b00, 0, 4'h2, 5);
      add(1, I_SW, 0, 1, 4'd2, C_MA,  2'b00, 0, 4'h2, 5);
      add(1, I_SW, 0, 0, 4'd5, C_MW,  2'b00, 0, 4'h2, 5);
      add(0, I_SW, 0, 0, 4'd5, C_MWR, 2'b00, 0, 4'h2, 5);
      // 17 R-types from a cleared counter; the 4-bit instance wraps to 1
      for (int k = 0; k < 17; k++) begin
         add(1, I_SUB, 0, 1, 4'd0, C_F1,  2'b00, 0, (k == 0) ? 4'h0 : 4'h8, k);
         add(1, I_SUB, 0, 1, 4'd1, C_DEC, 2'b00, 0, (k == 0) ? 4'h0 : 4'h8, k);
         add(1, I_SUB, 0, 1, 4'd6, C_EXE, 2'b10, 0, 4'h8, k);
         add(1, I_SUB, 0, 1, 4'd7, C_AWB, 2'b00, 0, 4'h8, k);
      end
      add(1, 32'd0, 0, 0, 4'd0, C_F0, 2'b00, 0, 4'h8, 17);

      repeat (2) @(posedge clk);
      foreach (vq[i]) begin
         @(negedge clk);
         rst_n = vq[i].rst_n; instr = vq[i].instr; zero = vq[i].zero; mem_ready = vq[i].mr;
         #1;
         chk("state",   i, {28'd0, state},  {28'd0, vq[i].st});
         chk("ctl",     i, {21'd0, pc_en, pc_src, ir_write, i_or_d, mem_read, mem_write,
                            reg_write, mem_to_reg, alu_src_a, alu_src_b}, {21'd0, vq[i].ctl});
         chk("alu_op",  i, {30'd0, alu_op}, {30'd0, vq[i].aop});
         chk("illegal", i, {31'd0, illegal}, {31'd0, vq[i].ill});
         chk("funct",   i, {28'd0, funct},  {28'd0, vq[i].fn});
         chk("retire",  i, retire_cnt, vq[i].rc);
         rc_w = vq[i].rc;
         chk("retire4", i, {28'd0, n_retire_cnt}, {28'd0, rc_w[3:0]});
         chk("state4",  i, {28'd0, n_state}, {28'd0, vq[i].st});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
